// File: rtl/key_queue_ctrl.sv
// key_queue_ctrl
//   Buffers key codes from the keyboard IO block in a FIFO and delivers
//   them to the CPU. The CPU is interrupted at a limited rate and reads
//   one byte per request.
//
// Ports
//   sys_clk, reset       clock and synchronous active-high reset
//   key_strobe, key_code one-cycle key event and its 8-bit code
//   rd_req               CPU read request (pulse)
//   rd_valid             read response pulse, one cycle after rd_req
//   rd_data              popped code, 0 for an empty read, held until next read
//   rd_empty             the read response found the queue empty
//   irq_en, irq, irq_ack interrupt enable, level interrupt, acknowledge pulse
//   count                queue occupancy, 0..DEPTH
//   overflow, ovf_clr    sticky lost-key flag and its clear
//
// Build option
//   KEYQ_DROP_NULL_EN : when defined, strobes carrying code 0 are discarded
//                       (not stored, no overflow, no interrupt wake-up).
module key_queue_ctrl #(
  parameter int DEPTH   = 8,
  parameter int HOLDOFF = 16
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     key_strobe,
  input  logic [7:0]               key_code,
  input  logic                     rd_req,
  output logic                     rd_valid,
  output logic [7:0]               rd_data,
  output logic                     rd_empty,
  input  logic                     irq_en,
  output logic                     irq,
  input  logic                     irq_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [7:0]    HOLD_LD  = 8'(HOLDOFF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_HOLD
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          rd_valid_q, rd_valid_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_empty_q, rd_empty_d;
  logic          irq_q, irq_d;
  state_t        state_q, state_d;
  logic [7:0]    timer_q, timer_d;

  logic code_ok;
  logic q_full;
  logic q_empty;
  logic do_pop;
  logic do_push;

`ifdef KEYQ_DROP_NULL_EN
  assign code_ok = (key_code != 8'd0);
`else
  assign code_ok = 1'b1;
`endif

  assign q_full  = (count_q == FULL_CNT);
  assign q_empty = (count_q == '0);
  assign do_pop  = rd_req && !q_empty;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign do_push = key_strobe && code_ok && (!q_full || do_pop);

  // FIFO pointers, occupancy, read response and overflow flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rd_valid_d = rd_req;
    rd_data_d  = rd_data_q;
    rd_empty_d = rd_empty_q;

    if (rd_req) begin
      rd_empty_d = q_empty;
      rd_data_d  = q_empty ? 8'd0 : mem_q[rd_ptr_q];
    end

    // Pointers are PW bits wide, so the increment wraps modulo DEPTH.
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Setting has priority over a simultaneous clear.
    if (key_strobe && code_ok && q_full && !do_pop) overflow_d = 1'b1;
    else if (ovf_clr)                                overflow_d = 1'b0;
  end

  // Interrupt pacing FSM
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (!q_empty && irq_en) state_d = S_ASSERT;
      end
      S_ASSERT: begin
        if (irq_ack) begin
          state_d = S_HOLD;
          timer_d = HOLD_LD;
        end else if (!irq_en || q_empty) begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        timer_d = timer_q - 8'd1;
        // Acks are ignored here; the timer is never reloaded mid-holdoff.
        if (timer_q <= 8'd1) begin
          state_d = S_IDLE;
          timer_d = 8'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = 8'd0;
      end
    endcase
    irq_d = (state_d == S_ASSERT);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'd0;
      rd_empty_q <= 1'b0;
      irq_q      <= 1'b0;
      state_q    <= S_IDLE;
      timer_q    <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_empty_q <= rd_empty_d;
      irq_q      <= irq_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge sys_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= key_code;
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_empty = rd_empty_q;
  assign irq      = irq_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
